// File: rtl/router_pkt_gen.sv
// Packet source for the 1x3 router: buffers a payload, then frames header/payload/parity under busy back-pressure.
// Optional build macro ROUTER_PKT_GEN_CORRUPT_EN adds a corrupt input that inverts the transmitted parity byte.
module router_pkt_gen #(
   parameter int GAP_CYCLES = 2
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        start,
   input  logic [1:0]  dest,
   input  logic [5:0]  len,
`ifdef ROUTER_PKT_GEN_CORRUPT_EN
   input  logic        corrupt,
`endif
   input  logic [7:0]  pay_data,
   input  logic        pay_valid,
   output logic        pay_ready,
   input  logic        busy,
   input  logic        err,
   output logic        packet_valid,
   output logic [7:0]  data_out,
   output logic        idle,
   output logic        reject,
   output logic        done,
   output logic        pkt_err,
   output logic [15:0] pkt_cnt
);

   // state     | meaning
   // S_IDLE    | waiting for a request; start sampled here only
   // S_FILL    | accepting payload bytes into the buffer
   // S_HEADER  | header byte on data_out, packet_valid high
   // S_PAYLOAD | buffered bytes on data_out, packet_valid high
   // S_PARITY  | parity byte on data_out, packet_valid low
   // S_GAP     | inter-packet gap, collecting the router err flag
   typedef enum logic [2:0] {
      S_IDLE,
      S_FILL,
      S_HEADER,
      S_PAYLOAD,
      S_PARITY,
      S_GAP
   } state_t;

   localparam logic [3:0] GAP_LOAD = 4'(GAP_CYCLES - 1);

   state_t      state_q, state_d;
   logic [1:0]  dest_q, dest_d;
   logic [5:0]  len_q, len_d;
   logic [5:0]  idx_q, idx_d;
   logic [7:0]  parity_q, parity_d;
   logic [3:0]  gap_q, gap_d;
   logic        err_flag_q, err_flag_d;
   logic        corrupt_q, corrupt_d;
   logic        buf_we;
   logic [7:0]  buf_q [64];

   logic        packet_valid_q, packet_valid_d;
   logic [7:0]  data_out_q, data_out_d;
   logic        pay_ready_q, pay_ready_d;
   logic        idle_q, idle_d;
   logic        reject_q, reject_d;
   logic        done_q, done_d;
   logic        pkt_err_q, pkt_err_d;
   logic [15:0] pkt_cnt_q, pkt_cnt_d;

   logic        corrupt_in;
   logic        req_legal;
   logic        last_idx;

`ifdef ROUTER_PKT_GEN_CORRUPT_EN
   assign corrupt_in = corrupt;
`else
   assign corrupt_in = 1'b0;
`endif

   assign req_legal = (dest != 2'd3) && (len != 6'd0);
   assign last_idx  = (idx_q == (len_q - 6'd1));

   always_comb begin
      state_d        = state_q;
      dest_d         = dest_q;
      len_d          = len_q;
      idx_d          = idx_q;
      parity_d       = parity_q;
      gap_d          = gap_q;
      err_flag_d     = err_flag_q;
      corrupt_d      = corrupt_q;
      buf_we         = 1'b0;
      reject_d       = 1'b0;
      done_d         = 1'b0;
      pkt_err_d      = pkt_err_q;
      pkt_cnt_d      = pkt_cnt_q;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               if (req_legal) begin
                  state_d   = S_FILL;
                  dest_d    = dest;
                  len_d     = len;
                  idx_d     = 6'd0;
                  parity_d  = {len, dest};
                  corrupt_d = corrupt_in;
               end else begin
                  reject_d  = 1'b1;
               end
            end
         end
         S_FILL: begin
            if (pay_valid) begin
               buf_we   = 1'b1;
               parity_d = parity_q ^ pay_data;
               if (last_idx) begin
                  state_d = S_HEADER;
                  idx_d   = 6'd0;
               end else begin
                  idx_d   = idx_q + 6'd1;
               end
            end
         end
         S_HEADER: begin
            if (!busy) state_d = S_PAYLOAD;
         end
         S_PAYLOAD: begin
            if (!busy) begin
               if (last_idx) begin
                  state_d = S_PARITY;
                  idx_d   = 6'd0;
               end else begin
                  idx_d   = idx_q + 6'd1;
               end
            end
         end
         S_PARITY: begin
            if (!busy) begin
               state_d    = S_GAP;
               gap_d      = GAP_LOAD;
               err_flag_d = 1'b0;
            end
         end
         S_GAP: begin
            // err sampled on the final gap cycle still counts toward this packet
            if (gap_q == 4'd0) begin
               state_d    = S_IDLE;
               done_d     = 1'b1;
               pkt_err_d  = err_flag_q | err;
               pkt_cnt_d  = pkt_cnt_q + 16'd1;
               err_flag_d = 1'b0;
            end else begin
               gap_d      = gap_q - 4'd1;
               err_flag_d = err_flag_q | err;
            end
         end
         default: state_d = S_IDLE;
      endcase

      // Outputs are registered from the next state so they line up with state_q.
      packet_valid_d = (state_d == S_HEADER) || (state_d == S_PAYLOAD);
      pay_ready_d    = (state_d == S_FILL);
      idle_d         = (state_d == S_IDLE);
      case (state_d)
         S_HEADER:  data_out_d = {len_q, dest_q};
         S_PAYLOAD: data_out_d = buf_q[idx_d];
         S_PARITY:  data_out_d = parity_q ^ {8{corrupt_q}};
         default:   data_out_d = 8'h00;
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q        <= S_IDLE;
         dest_q         <= 2'd0;
         len_q          <= 6'd0;
         idx_q          <= 6'd0;
         parity_q       <= 8'h00;
         gap_q          <= 4'd0;
         err_flag_q     <= 1'b0;
         corrupt_q      <= 1'b0;
         packet_valid_q <= 1'b0;
         data_out_q     <= 8'h00;
         pay_ready_q    <= 1'b0;
         idle_q         <= 1'b1;
         reject_q       <= 1'b0;
         done_q         <= 1'b0;
         pkt_err_q      <= 1'b0;
         pkt_cnt_q      <= 16'd0;
      end else begin
         state_q        <= state_d;
         dest_q         <= dest_d;
         len_q          <= len_d;
         idx_q          <= idx_d;
         parity_q       <= parity_d;
         gap_q          <= gap_d;
         err_flag_q     <= err_flag_d;
         corrupt_q      <= corrupt_d;
         packet_valid_q <= packet_valid_d;
         data_out_q     <= data_out_d;
         pay_ready_q    <= pay_ready_d;
         idle_q         <= idle_d;
         reject_q       <= reject_d;
         done_q         <= done_d;
         pkt_err_q      <= pkt_err_d;
         pkt_cnt_q      <= pkt_cnt_d;
      end
   end

   // Payload storage carries no reset; contents are only read after being written.
   always_ff @(posedge clk) begin
      if (buf_we) buf_q[idx_q] <= pay_data;
   end

   assign packet_valid = packet_valid_q;
   assign data_out     = data_out_q;
   assign pay_ready    = pay_ready_q;
   assign idle         = idle_q;
   assign reject       = reject_q;
   assign done         = done_q;
   assign pkt_err      = pkt_err_q;
   assign pkt_cnt      = pkt_cnt_q;

endmodule

// File: tb/tb_router_pkt_gen.sv
// Self-checking bench for router_pkt_gen: vector table, directed corner sequences and randomized packets.
module tb_router_pkt_gen;

   localparam int GAP = 2;

   logic        clk = 1'b0;
   logic        resetn = 1'b0;
   logic        start = 1'b0;
   logic [1:0]  dest = 2'd0;
   logic [5:0]  len = 6'd0;
   logic [7:0]  pay_data = 8'h00;
   logic        pay_valid = 1'b0;
   logic        busy = 1'b0;
   logic        err = 1'b0;
   logic        pay_ready, packet_valid, idle, reject, done, pkt_err;
   logic [7:0]  data_out;
   logic [15:0] pkt_cnt;
`ifdef ROUTER_PKT_GEN_CORRUPT_EN
   logic        corrupt = 1'b0;
`endif

   int total = 0;
   int bad = 0;
   int model_cnt = 0;
   logic [7:0] pay_q[$];

   typedef struct {
      logic [1:0] d;
      logic [5:0] l;
      bit         rej;
      logic [7:0] hdr;
   } vec_t;
   vec_t vt[7];

   always #5 clk = ~clk;

   router_pkt_gen #(.GAP_CYCLES(GAP)) dut (
      .clk          (clk),
      .resetn       (resetn),
      .start        (start),
      .dest         (dest),
      .len          (len),
`ifdef ROUTER_PKT_GEN_CORRUPT_EN
      .corrupt      (corrupt),
`endif
      .pay_data     (pay_data),
      .pay_valid    (pay_valid),
      .pay_ready    (pay_ready),
      .busy         (busy),
      .err          (err),
      .packet_valid (packet_valid),
      .data_out     (data_out),
      .idle         (idle),
      .reject       (reject),
      .done         (done),
      .pkt_err      (pkt_err),
      .pkt_cnt      (pkt_cnt)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic do_reset();
      resetn = 1'b0; start = 1'b0; pay_valid = 1'b0; busy = 1'b0; err = 1'b0;
      @(negedge clk);
      @(negedge clk);
      resetn = 1'b1;
      model_cnt = 0;
      @(negedge clk);
   endtask

   task automatic fill_random(input int l);
      pay_q.delete();
      for (int i = 0; i < l; i++) pay_q.push_back(8'($urandom));
   endtask

   task automatic try_reject(input logic [1:0] d, input logic [5:0] l);
      start = 1'b1; dest = d; len = l;
      @(negedge clk);
      start = 1'b0;
      chk("rej_pulse", 32'(reject), 1);
      chk("rej_idle", 32'(idle), 1);
      chk("rej_ready", 32'(pay_ready), 0);
      chk("rej_pv", 32'(packet_valid), 0);
      @(negedge clk);
      chk("rej_clear", 32'(reject), 0);
      chk("rej_idle2", 32'(idle), 1);
   endtask

   // fill_mode: 0 continuous, 1 every other cycle, 2 random pay_valid.
   // err_at: -1 none, -2 err noise outside the gap only, >=0 gap cycle that raises err.
   task automatic send_pkt(input logic [1:0] d, input logic [5:0] l, input logic [7:0] exp_hdr,
                           input int busy_pct, input int hold_pos, input int hold_len,
                           input int fill_mode, input int err_at, input bit corr);
      logic [7:0] exp_s[$];
      logic [7:0] par;
      int  n, pos, held, budget, i, cyc, bad0;
      bit  v, b, exp_pv;
      bad0 = bad;
      par = exp_hdr;
      exp_s.push_back(exp_hdr);
      foreach (pay_q[k]) begin
         exp_s.push_back(pay_q[k]);
         par = par ^ pay_q[k];
      end
      if (corr) par = ~par;
      exp_s.push_back(par);
      n = exp_s.size();
`ifdef ROUTER_PKT_GEN_CORRUPT_EN
      corrupt = corr;
`endif
      start = 1'b1; dest = d; len = l;
      @(negedge clk);
      start = 1'b0;
      chk("req_ready", 32'(pay_ready), 1);
      chk("req_idle", 32'(idle), 0);
      chk("req_done", 32'(done), 0);
      i = 0; cyc = 0;
      while (i < int'(l)) begin
         case (fill_mode)
            0:       v = 1'b1;
            1:       v = (cyc % 2) == 0;
            default: v = 1'($urandom_range(0, 1));
         endcase
         if (cyc > 500) v = 1'b1;
         pay_valid = v;
         pay_data  = v ? pay_q[i] : 8'($urandom);
         if (err_at == -2) err = 1'($urandom_range(0, 1));
         @(negedge clk);
         if (v) i++;
         cyc++;
      end
      pay_valid = 1'b0;
      chk("hdr_ready", 32'(pay_ready), 0);
      pos = 0; held = 0; budget = 0;
      while (pos < n) begin
         exp_pv = (pos < n - 1);
         total++;
         if (packet_valid !== exp_pv || data_out !== exp_s[pos]) begin
            bad++;
            $display("FAIL stream[%0d]: got pv=%0b data=%02h expected pv=%0b data=%02h",
                     pos, packet_valid, data_out, exp_pv, exp_s[pos]);
            break;
         end
         if (pos == hold_pos && held < hold_len) begin
            b = 1'b1;
            held++;
         end else begin
            b = ($urandom_range(0, 99) < busy_pct) && (budget < 3000);
         end
         busy = b;
         if (err_at == -2) err = 1'($urandom_range(0, 1));
         @(negedge clk);
         if (!b) pos++;
         budget++;
      end
      busy = 1'b0;
      err  = 1'b0;
      if (bad == bad0) begin
         for (int g = 0; g < GAP; g++) begin
            chk("gap_pv", 32'(packet_valid), 0);
            chk("gap_data", 32'(data_out), 0);
            chk("gap_done", 32'(done), 0);
            err = (g == err_at);
            @(negedge clk);
         end
         err = 1'b0;
         model_cnt++;
         chk("done_pulse", 32'(done), 1);
         chk("done_idle", 32'(idle), 1);
         chk("done_err", 32'(pkt_err), 32'(err_at >= 0));
         chk("done_cnt", 32'(pkt_cnt), 32'(model_cnt[15:0]));
      end
      if (bad != bad0) do_reset();
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [1:0] rd;
      logic [5:0] rl;
      int         ea;

      vt[0] = '{2'd1, 6'd3,  1'b0, 8'h0D};
      vt[1] = '{2'd3, 6'd5,  1'b1, 8'h00};
      vt[2] = '{2'd0, 6'd0,  1'b1, 8'h00};
      vt[3] = '{2'd3, 6'd0,  1'b1, 8'h00};
      vt[4] = '{2'd2, 6'd63, 1'b0, 8'hFE};
      vt[5] = '{2'd0, 6'd1,  1'b0, 8'h04};
      vt[6] = '{2'd2, 6'd10, 1'b0, 8'h2A};

      @(negedge clk);
      @(negedge clk);
      chk("rst_pv", 32'(packet_valid), 0);
      chk("rst_data", 32'(data_out), 0);
      chk("rst_ready", 32'(pay_ready), 0);
      chk("rst_idle", 32'(idle), 1);
      chk("rst_reject", 32'(reject), 0);
      chk("rst_done", 32'(done), 0);
      chk("rst_pkt_err", 32'(pkt_err), 0);
      chk("rst_cnt", 32'(pkt_cnt), 0);
      resetn = 1'b1;
      @(negedge clk);

      // basic packet: 0D A1 B2 C3 then parity DD
      pay_q = '{8'hA1, 8'hB2, 8'hC3};
      send_pkt(2'd1, 6'd3, 8'h0D, 0, -1, 0, 0, -1, 1'b0);
      // back-to-back start in the done cycle, busy held 3 cycles on B2
      send_pkt(2'd1, 6'd3, 8'h0D, 0, 2, 3, 0, -1, 1'b0);
      @(negedge clk);
      chk("done_once", 32'(done), 0);

      for (int t = 0; t < 7; t++) begin
         if (vt[t].rej) begin
            try_reject(vt[t].d, vt[t].l);
         end else begin
            fill_random(int'(vt[t].l));
            send_pkt(vt[t].d, vt[t].l, vt[t].hdr, 30, -1, 0, 2, -1, 1'b0);
         end
      end

      // max length with gapped payload valid
      pay_q.delete();
      for (int k = 0; k < 63; k++) pay_q.push_back(8'(k));
      send_pkt(2'd0, 6'd63, 8'hFC, 0, -1, 0, 1, -1, 1'b0);

      // router err in the gap, then a clean packet, then err noise outside the gap
      fill_random(4);
      send_pkt(2'd2, 6'd4, 8'h12, 0, -1, 0, 0, 0, 1'b0);
      fill_random(4);
      send_pkt(2'd2, 6'd4, 8'h12, 0, -1, 0, 0, -1, 1'b0);
      fill_random(5);
      send_pkt(2'd1, 6'd5, 8'h15, 20, -1, 0, 0, GAP - 1, 1'b0);
      fill_random(6);
      send_pkt(2'd0, 6'd6, 8'h18, 20, -1, 0, 0, -2, 1'b0);
`ifdef ROUTER_PKT_GEN_CORRUPT_EN
      fill_random(3);
      send_pkt(2'd1, 6'd3, 8'h0D, 0, -1, 0, 0, -1, 1'b1);
`endif

      // asynchronous reset in the middle of the payload
      start = 1'b1; dest = 2'd2; len = 6'd5;
      @(negedge clk);
      start = 1'b0;
      for (int k = 0; k < 5; k++) begin
         pay_valid = 1'b1;
         pay_data  = 8'(8'h11 * (k + 1));
         @(negedge clk);
      end
      pay_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("mid_pv", 32'(packet_valid), 1);
      #2 resetn = 1'b0;
      #1;
      chk("arst_pv", 32'(packet_valid), 0);
      chk("arst_data", 32'(data_out), 0);
      chk("arst_idle", 32'(idle), 1);
      chk("arst_cnt", 32'(pkt_cnt), 0);
      @(negedge clk);
      resetn = 1'b1;
      model_cnt = 0;
      @(negedge clk);
      chk("post_rst_idle", 32'(idle), 1);
      chk("post_rst_pv", 32'(packet_valid), 0);
      pay_q = '{8'hA1, 8'hB2, 8'hC3};
      send_pkt(2'd1, 6'd3, 8'h0D, 0, -1, 0, 0, -1, 1'b0);

      // randomized traffic against the stream model
      for (int r = 0; r < 40; r++) begin
         repeat ($urandom_range(0, 2)) @(negedge clk);
         if ($urandom_range(0, 7) == 0) begin
            if ($urandom_range(0, 1) == 1) try_reject(2'd3, 6'($urandom_range(0, 63)));
            else try_reject(2'($urandom_range(0, 2)), 6'd0);
         end else begin
            rd = 2'($urandom_range(0, 2));
            rl = 6'($urandom_range(1, 63));
            ea = $urandom_range(0, 3) == 0 ? $urandom_range(0, GAP - 1) : -1;
            fill_random(int'(rl));
            send_pkt(rd, rl, {rl, rd}, $urandom_range(0, 60), -1, 0,
                     $urandom_range(0, 2), ea, 1'b0);
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
